// File: rtl/rosc_pkg.sv
`timescale 1ns/1ps
// Shared types and width helpers for the ring-oscillator meter.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM state encoding and a $clog2 variant that never returns 0.
package rosc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // A zero-width select or timer is illegal, so clamp to one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ring_osc_core.sv
`timescale 1ns/1ps
// Gated NAND + inverter-chain ring; osc is the selected feedback tap (odd inversion count).
// Latency: free-running, period 2*(2*(tap_q+1)+1)*INV_DELAY; static at 1 while ring_en=0.
// Backpressure: none. INV_DELAY shapes simulation only; keep attributes hold the loop in synthesis.
module ring_osc_core
    import rosc_pkg::*;
#(
    parameter int RING_STAGES = 8,
    parameter int NUM_TAPS    = RING_STAGES / 2,
    parameter int INV_DELAY   = 5,
    localparam int SEL_W      = clog2_min1(NUM_TAPS)
)(
    input  logic             ring_en,
    input  logic [SEL_W-1:0] tap_q,
    output logic             osc
);

    (* keep = "true", dont_touch = "true" *) logic                   nand_out;
    (* keep = "true", dont_touch = "true" *) logic [RING_STAGES-1:0] chain;
    (* keep = "true", dont_touch = "true" *) logic                   fb;

    assign #(INV_DELAY) nand_out = ~(ring_en & fb);
    assign #(INV_DELAY) chain[0] = ~nand_out;

    for (genvar i = 1; i < RING_STAGES; i++) begin : g_inv
        assign #(INV_DELAY) chain[i] = ~chain[i-1];
    end

    // Tap i closes the loop after 2*(i+1) inverters; out-of-range selects use the longest tap.
    always_comb begin
        fb = chain[2*NUM_TAPS-1];
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (tap_q == SEL_W'(i)) fb = chain[2*i+1];
        end
    end

    assign osc = fb;

endmodule

// File: rtl/ring_osc_meter.sv
`timescale 1ns/1ps
// Ring oscillator plus clk-domain edge counter over a WIN_CYC window; ROSC_CONTINUOUS_EN re-arms automatically.
// Latency: start accepted -> done after SETTLE_CYC + WIN_CYC + 1 cycles.
// Backpressure: start is a level; ignored while busy (continuous build: only queues the next tap).
module ring_osc_meter
    import rosc_pkg::*;
#(
    parameter int RING_STAGES = 8,
    parameter int NUM_TAPS    = RING_STAGES / 2,
    parameter int WIN_CYC     = 256,
    parameter int SETTLE_CYC  = 4,
    parameter int CNT_W       = 8,
    parameter int INV_DELAY   = 5,
    localparam int SEL_W      = clog2_min1(NUM_TAPS)
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] tap_sel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             osc_out
);

    localparam int TMR_W = clog2_min1(((WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC) + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q;
    logic               ring_en;
    logic [SEL_W-1:0]   tap_q;
    logic [SEL_W-1:0]   tap_pend;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   acc;
    logic               acc_ovf;
    logic [CNT_W-1:0]   acc_nxt;
    logic               ovf_nxt;
    logic               sync1, sync2, prev;
    logic               rise;
    logic               launch;
    logic               win_end;

    ring_osc_core #(
        .RING_STAGES (RING_STAGES),
        .NUM_TAPS    (NUM_TAPS),
        .INV_DELAY   (INV_DELAY)
    ) u_core (
        .ring_en (ring_en),
        .tap_q   (tap_q),
        .osc     (osc_out)
    );

    // osc_out is asynchronous to clk; two flops before anything looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= osc_out;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise    = sync2 & ~prev;
    assign win_end = (state_q == ST_MEASURE) && (timer == TMR_W'(WIN_CYC - 1));

    always_comb begin
        acc_nxt = acc;
        ovf_nxt = acc_ovf;
        if (rise) begin
            if (acc == CNT_MAX) ovf_nxt = 1'b1;
            else                acc_nxt = acc + 1'b1;
        end
    end

`ifdef ROSC_CONTINUOUS_EN
    localparam bit CONT = 1'b1;

    logic [CNT_W-1:0] res_cnt;
    logic             res_ovf;

    // Published result only moves at window end so readers see a stable value between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt <= '0;
            res_ovf <= 1'b0;
        end else if (launch) begin
            res_cnt <= '0;
            res_ovf <= 1'b0;
        end else if (win_end) begin
            res_cnt <= acc_nxt;
            res_ovf <= ovf_nxt;
        end
    end

    assign count    = res_cnt;
    assign overflow = res_ovf;
`else
    localparam bit CONT = 1'b0;

    assign count    = acc;
    assign overflow = acc_ovf;
`endif

    assign launch = start && ((state_q == ST_IDLE) || (!CONT && state_q == ST_DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ring_en  <= 1'b0;
            tap_q    <= '0;
            tap_pend <= '0;
            timer    <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
        end else if (launch) begin
            state_q  <= ST_SETTLE;
            ring_en  <= 1'b1;
            tap_q    <= tap_sel;
            tap_pend <= tap_sel;
            timer    <= '0;
            acc      <= '0;
            acc_ovf  <= 1'b0;
        end else begin
            if (CONT && start && state_q != ST_IDLE) tap_pend <= tap_sel;
            case (state_q)
                ST_SETTLE: begin
                    if (timer == TMR_W'(SETTLE_CYC - 1)) begin
                        state_q <= ST_MEASURE;
                        timer   <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    acc     <= acc_nxt;
                    acc_ovf <= ovf_nxt;
                    timer   <= timer + 1'b1;
                    if (win_end) begin
                        state_q <= ST_DONE;
                        ring_en <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (CONT) begin
                        state_q <= ST_SETTLE;
                        ring_en <= 1'b1;
                        tap_q   <= start ? tap_sel : tap_pend;
                        timer   <= '0;
                        acc     <= '0;
                        acc_ovf <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_SETTLE) || (state_q == ST_MEASURE);
    assign done = (state_q == ST_DONE);

endmodule
